// File: rtl/branch_resolve_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_if
// Brief    : Instruction-in / branch-result-out handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_resolve_if;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [2:0]  nzp;
    logic        ld_cc;
    logic        br_valid;
    logic        br_ready;
    logic        br_taken;
    logic [15:0] br_target;
    logic [7:0]  taken_cnt;

    // master drives instructions and consumes results; slave is the resolver
    modport master (
        output ir_valid, ir, pc, nzp, ld_cc, br_ready,
        input  ir_ready, br_valid, br_taken, br_target, taken_cnt
    );

    modport slave (
        input  ir_valid, ir, pc, nzp, ld_cc, br_ready,
        output ir_ready, br_valid, br_taken, br_target, taken_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Brief    : Resolves BR instructions (BEN + target) with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve (
    input  wire logic       clk,
    input  wire logic       reset,
    branch_resolve_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_OP_BR  = 4'b0000;
    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    state_t      r_state;
    logic [15:0] r_ir;
    logic [15:0] r_pc;
    logic        r_br_valid;
    logic        r_br_taken;
    logic [15:0] r_br_target;
    logic [7:0]  r_taken_cnt;

    logic        w_is_br;
    logic        w_taken;
    logic [15:0] w_offset;
    logic [15:0] w_target;

    always_comb begin
        w_is_br  = (r_ir[15:12] == c_OP_BR);
        w_taken  = w_is_br && (|(r_ir[11:9] & bus.nzp));
        w_offset = {{7{r_ir[8]}}, r_ir[8:0]};
        w_target = w_taken ? (r_pc + w_offset) : r_pc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ir        <= 16'h0000;
            r_pc        <= 16'h0000;
            r_br_valid  <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= 16'h0000;
            r_taken_cnt <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ir_valid) begin
                        r_ir    <= bus.ir;
                        r_pc    <= bus.pc;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    // a CC load landing this edge makes nzp stale; wait for it
                    if (!bus.ld_cc) begin
                        r_br_taken  <= w_taken;
                        r_br_target <= w_target;
                        r_br_valid  <= 1'b1;
                        if (w_taken && (r_taken_cnt != c_CNT_MAX)) begin
                            r_taken_cnt <= r_taken_cnt + 8'd1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.br_ready) begin
                        r_br_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_br_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ir_ready  = (r_state == S_IDLE) && reset;
    assign bus.br_valid  = r_br_valid;
    assign bus.br_taken  = r_br_taken;
    assign bus.br_target = r_br_target;
    assign bus.taken_cnt = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve
// Brief    : Directed + randomized self-checking bench for branch_resolve.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

    logic clk;
    logic reset;

    branch_resolve_if bif ();

    branch_resolve dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          model_cnt;
    logic        last_taken;
    logic [15:0] last_target;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Branch semantics computed with plain integer arithmetic
    function automatic void model(input logic [15:0] i, input logic [15:0] p,
                                  input logic [2:0] n, output logic t,
                                  output logic [15:0] tgt);
        int off;
        int sum;
        off = int'(i[8:0]);
        if (off >= 256) off = off - 512;
        t   = (i[15:12] == 4'd0) && ((i[11:9] & n) != 3'd0);
        sum = (int'(p) + off + 65536) % 65536;
        tgt = t ? sum[15:0] : p;
    endfunction

    task automatic run_txn(input logic [15:0] t_ir, input logic [15:0] t_pc,
                           input logic [2:0] t_nzp0, input logic [2:0] t_nzp1,
                           input int t_ldcc, input int t_stall);
        logic        exp_taken;
        logic [15:0] exp_target;
        int          lat;
        bit          seen;
        model(t_ir, t_pc, t_nzp1, exp_taken, exp_target);
        @(negedge clk);
        check("ir_ready_idle", 32'(bif.ir_ready), 32'd1);
        bif.ir_valid = 1'b1;
        bif.ir       = t_ir;
        bif.pc       = t_pc;
        bif.nzp      = t_nzp0;
        bif.ld_cc    = 1'b0;
        bif.br_ready = 1'b0;
        seen = 0;
        lat  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bif.ir_valid = 1'b0;
            bif.ir       = 16'($urandom);
            bif.pc       = 16'($urandom);
            if (bif.br_valid) begin
                seen = 1;
                lat  = k;
                break;
            end
            check("ir_ready_eval", 32'(bif.ir_ready), 32'd0);
            bif.ld_cc = (k <= t_ldcc);
            bif.nzp   = (k <= t_ldcc) ? t_nzp0 : t_nzp1;
        end
        bif.ld_cc = 1'b0;
        check("latency", 32'(lat), 32'(t_ldcc + 2));
        if (!seen) return;
        if (exp_taken && model_cnt < 255) model_cnt++;
        last_taken  = bif.br_taken;
        last_target = bif.br_target;
        // a second instruction offered during RESP must not be accepted
        bif.ir_valid = 1'b1;
        for (int s = 0; s <= t_stall; s++) begin
            if (s > 0) @(negedge clk);
            check("resp_valid", 32'(bif.br_valid), 32'd1);
            check("resp_taken", 32'(bif.br_taken), 32'(exp_taken));
            check("resp_target", 32'(bif.br_target), 32'(exp_target));
            check("resp_ir_ready", 32'(bif.ir_ready), 32'd0);
        end
        check("taken_cnt", 32'(bif.taken_cnt), 32'(model_cnt));
        bif.br_ready = 1'b1;
        @(negedge clk);
        bif.br_ready = 1'b0;
        bif.ir_valid = 1'b0;
        check("post_hs_valid", 32'(bif.br_valid), 32'd0);
        check("post_hs_ir_ready", 32'(bif.ir_ready), 32'd1);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        model_cnt    = 0;
        reset        = 1'b0;
        bif.ir_valid = 1'b0;
        bif.ir       = 16'h0000;
        bif.pc       = 16'h0000;
        bif.nzp      = 3'b000;
        bif.ld_cc    = 1'b0;
        bif.br_ready = 1'b0;

        #2;
        check("rst_ir_ready", 32'(bif.ir_ready), 32'd0);
        check("rst_br_valid", 32'(bif.br_valid), 32'd0);
        check("rst_br_taken", 32'(bif.br_taken), 32'd0);
        check("rst_br_target", 32'(bif.br_target), 32'h0000);
        check("rst_taken_cnt", 32'(bif.taken_cnt), 32'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_ir_ready", 32'(bif.ir_ready), 32'd1);

        // BRz taken
        run_txn(16'h0405, 16'h3001, 3'b010, 3'b010, 0, 0);
        check("brz_taken", 32'(last_taken), 32'd1);
        check("brz_target", 32'(last_target), 32'h3006);
        check("brz_cnt", 32'(bif.taken_cnt), 32'd1);

        // BRn with negative offset, not taken then taken
        run_txn(16'h09FE, 16'h3010, 3'b001, 3'b001, 0, 0);
        check("brn_nt_taken", 32'(last_taken), 32'd0);
        check("brn_nt_target", 32'(last_target), 32'h3010);
        run_txn(16'h09FE, 16'h3010, 3'b100, 3'b100, 0, 0);
        check("brn_t_taken", 32'(last_taken), 32'd1);
        check("brn_t_target", 32'(last_target), 32'h300E);

        // CC update during evaluation: stale nzp must be ignored
        run_txn(16'h09FE, 16'h3010, 3'b001, 3'b100, 2, 0);
        check("ldcc_taken", 32'(last_taken), 32'd1);

        // backpressure
        run_txn(16'h0405, 16'h3001, 3'b010, 3'b010, 0, 5);
        check("bp_target", 32'(last_target), 32'h3006);

        // non-BR, zero nzp, wrap-around
        run_txn(16'h1261, 16'h4000, 3'b111, 3'b111, 0, 0);
        check("add_taken", 32'(last_taken), 32'd0);
        check("add_target", 32'(last_target), 32'h4000);
        run_txn(16'h0E05, 16'h2000, 3'b000, 3'b000, 0, 0);
        check("nzp0_taken", 32'(last_taken), 32'd0);
        run_txn(16'h0005, 16'h2000, 3'b111, 3'b111, 0, 0);
        check("mask0_taken", 32'(last_taken), 32'd0);
        run_txn(16'h0E01, 16'hFFFF, 3'b010, 3'b010, 0, 0);
        check("wrap_up_target", 32'(last_target), 32'h0000);
        run_txn(16'h0FFF, 16'h0000, 3'b001, 3'b001, 0, 0);
        check("wrap_dn_target", 32'(last_target), 32'hFFFF);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [15:0] r_ir;
            r_ir = 16'($urandom);
            if ($urandom_range(0, 1) == 0) r_ir[15:12] = 4'd0;
            run_txn(r_ir, 16'($urandom), 3'($urandom), 3'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        // reset in RESP abandons the result
        @(negedge clk);
        bif.ir_valid = 1'b1;
        bif.ir       = 16'h0405;
        bif.pc       = 16'h3001;
        bif.nzp      = 3'b010;
        @(negedge clk);
        bif.ir_valid = 1'b0;
        @(negedge clk);
        check("mid_resp_valid", 32'(bif.br_valid), 32'd1);
        reset = 1'b0;
        #1;
        model_cnt = 0;
        check("mid_rst_valid", 32'(bif.br_valid), 32'd0);
        check("mid_rst_ir_ready", 32'(bif.ir_ready), 32'd0);
        check("mid_rst_taken", 32'(bif.br_taken), 32'd0);
        check("mid_rst_target", 32'(bif.br_target), 32'h0000);
        check("mid_rst_cnt", 32'(bif.taken_cnt), 32'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rel_ir_ready", 32'(bif.ir_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_late_result", 32'(bif.br_valid), 32'd0);
        end

        // saturation
        for (int n = 0; n < 260; n++) begin
            logic [2:0] r_nzp;
            r_nzp = 3'($urandom_range(1, 7));
            run_txn({4'd0, 3'b111, 9'($urandom)}, 16'($urandom), r_nzp, r_nzp, 0, 0);
        end
        check("sat_cnt", 32'(bif.taken_cnt), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The module SHALL have one clock `clk` and one reset `reset`; `reset` is asynchronous and active-low (0 = in reset).
REQ-002 Ports, clock and reset first:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ir_valid`  in  1  an instruction is offered.
- `ir_ready`  out  1  the block can accept an instruction.
- `ir`  in  16  instruction word; [15:12] opcode, [11:9] n/z/p mask, [8:0] PCoffset9.
- `pc`  in  16  incremented PC that goes with `ir`.
- `nzp`  in  3  current condition-code register output {n,z,p}.
- `ld_cc`  in  1  condition-code register loads at this edge.
- `br_valid`  out  1  a resolution result is presented.
- `br_ready`  in  1  the consumer accepts the result.
- `br_taken`  out  1  the branch is taken (BEN).
- `br_target`  out  16  next PC.
- `taken_cnt`  out  8  count of taken branches, saturating.

Function
REQ-003 The state machine SHALL have three states, IDLE, EVAL and RESP; the state is held in flops.
REQ-004 `ir_ready` SHALL be 1 only when the state is IDLE and `reset` = 1.
REQ-005 In IDLE, when `ir_valid` and `ir_ready` are both 1, the block SHALL latch `ir` and `pc` and go to EVAL; otherwise it stays in IDLE.
REQ-006 In EVAL with `ld_cc` = 1, the block SHALL stay in EVAL and SHALL NOT sample `nzp`, because a condition-code update is landing at that edge.
REQ-007 In EVAL with `ld_cc` = 0, the block SHALL sample `nzp`, register the result and go to RESP.
REQ-008 For opcode 4'b0000 (BR):
- `br_taken` = |(latched ir[11:9] & nzp).
- `br_target` = latched pc + sign-extended ir[8:0], modulo 2^16 when taken; latched pc when not taken.
REQ-009 For any other opcode, the result SHALL be `br_taken` = 0 and `br_target` = latched pc.
REQ-010 In RESP, `br_valid` SHALL be 1, and `br_taken` and `br_target` SHALL stay stable until `br_valid` and `br_ready` are both 1 at a rising edge; the block then returns to IDLE.
REQ-011 `br_valid` SHALL be 0 in IDLE and EVAL.
REQ-012 Latency: with `ld_cc` = 0, `br_valid` SHALL assert exactly 2 cycles after the accepting edge. Each EVAL cycle with `ld_cc` = 1 adds one cycle.
REQ-013 There SHALL be no back-to-back acceptance. An instruction offered during RESP waits: `ir_ready` first returns to 1 in the cycle after the result handshake.
REQ-014 `taken_cnt` SHALL increment by 1 on the EVAL-to-RESP transition when the result is taken. It saturates at 8'hFF and never wraps.
REQ-015 `nzp` = 3'b000 (the condition-code register's reset value) SHALL resolve every BR as not taken, including mask 3'b111.
REQ-016 Mask 3'b000 SHALL always resolve as not taken.
REQ-017 Offset arithmetic SHALL wrap: pc = 16'hFFFF with offset +1 gives 16'h0000; pc = 16'h0000 with offset -1 gives 16'hFFFF.

Reset
REQ-018 While `reset` = 0, the block SHALL immediately hold:
- state = IDLE;
- `ir_ready` = 0, `br_valid` = 0, `br_taken` = 0;
- `br_target` = 16'h0000, `taken_cnt` = 8'h00.
REQ-019 Reset asserted in EVAL or RESP SHALL abandon the in-flight instruction; no result is presented afterward.
REQ-020 On the first rising edge after `reset` returns to 1, `ir_ready` SHALL be 1.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- BRz: ir = 16'h0405, pc = 16'h3001, nzp = 3'b010, `br_ready` held 1 -> `br_valid` 2 cycles after accept, `br_taken` = 1, `br_target` = 16'h3006, `taken_cnt` = 1.
- BRn, negative offset: ir = 16'h09FE, pc = 16'h3010, nzp = 3'b001 -> `br_taken` = 0, `br_target` = 16'h3010. Same with nzp = 3'b100 -> `br_taken` = 1, `br_target` = 16'h300E.
- Condition-code update during evaluation: `ld_cc` = 1 for 2 EVAL cycles while nzp changes 3'b001 -> 3'b100, BRn -> `br_valid` 4 cycles after accept, `br_taken` = 1.
- Backpressure: `br_ready` = 0 for 5 cycles in RESP -> `br_valid`, `br_taken` and `br_target` stable throughout, `ir_ready` = 0; handshake, then `ir_ready` = 1 the next cycle.
- Non-BR and wrap: ADD (16'h1261) -> `br_taken` = 0, `br_target` = pc. BRnzp with nzp = 3'b000 -> not taken. pc = 16'hFFFF with offset +1, taken -> `br_target` = 16'h0000.
- Reset and saturation: reset pulsed mid-RESP -> `br_valid` = 0 immediately and no late result. 260 taken branches -> `taken_cnt` = 8'hFF.
